// File: rtl/mux_rr_n_if.sv
// Handshake bundle for mux_rr_n: N producer lanes in, one consumer lane out.
// slave is the mux side, master is the environment driving it.
interface mux_rr_n_if #(
    parameter int WIDTH = 4,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) ();
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  mode,
        input  sel,
        output out_data,
        output out_ch,
        output out_valid,
        input  out_ready
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output mode,
        output sel,
        input  out_data,
        input  out_ch,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/mux_rr_n.sv
// N-channel registered mux with valid/ready lanes and
// fixed-select or round-robin arbitration into one output register.
module mux_rr_n #(
    parameter int WIDTH = 4,
    parameter int N     = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic       clk,
    input  logic       rst,
    mux_rr_n_if.slave  bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SELW-1:0]  ch_q, ch_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [SELW-1:0]  hi_idx, lo_idx, gnt;
    logic             hi_vld, lo_vld, gnt_vld;
    logic [WIDTH-1:0] gnt_data;
    logic             load_en, xfer;

    // Round-robin: lowest valid index at or above ptr, else lowest overall.
    always_comb begin
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (bus.in_valid[i]) begin
                lo_vld = 1'b1;
                lo_idx = SELW'(i);
                if (SELW'(i) >= ptr_q) begin
                    hi_vld = 1'b1;
                    hi_idx = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        if (bus.mode) begin
            gnt_vld = hi_vld | lo_vld;
            gnt     = hi_vld ? hi_idx : lo_idx;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.sel == SELW'(i) && bus.in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt     = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt == SELW'(i)) begin
                gnt_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load_en = (state_q == EMPTY) | bus.out_ready;
    assign xfer    = !rst & load_en & gnt_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = gnt_data;
            ch_d    = gnt;
            if (bus.mode) begin
                ptr_d = (gnt == SELW'(N - 1)) ? '0 : gnt + 1'b1;
            end
        end else if (load_en) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N; i++) begin
            bus.in_ready[i] = xfer && (gnt == SELW'(i));
        end
        bus.out_valid = (state_q == FULL);
        bus.out_data  = data_q;
        bus.out_ch    = ch_q;
    end
endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: directed scenarios plus random traffic
// checked against a behavioural arbitration model.
module tb_mux_rr_n;
    logic clk;
    logic rst;

    mux_rr_n_if #(.WIDTH(4), .N(8)) bus8 ();
    mux_rr_n_if #(.WIDTH(4), .N(5)) bus5 ();

    mux_rr_n #(.WIDTH(4), .N(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    mux_rr_n #(.WIDTH(4), .N(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    int total = 0;
    int bad   = 0;

    bit       m_valid;
    bit [3:0] m_data;
    int       m_ch;
    int       m_ptr;

    localparam logic [31:0] BASE = 32'hACF8_72B6;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Grant as the rules state it: fixed sel if in range and valid,
    // otherwise first valid channel scanning ptr, ptr+1, ... modulo 8.
    task automatic grant8(output bit gv, output int g);
        int s;
        int idx;
        gv = 0;
        g  = 0;
        if (!bus8.mode) begin
            s = int'(bus8.sel);
            if (s < 8 && bus8.in_valid[s]) begin
                gv = 1;
                g  = s;
            end
        end else begin
            for (int off = 0; off < 8; off++) begin
                idx = (m_ptr + off) % 8;
                if (!gv && bus8.in_valid[idx]) begin
                    gv = 1;
                    g  = idx;
                end
            end
        end
    endtask

    task automatic step8();
        bit         gv;
        int         g;
        bit         ld;
        logic [7:0] er;
        #1;
        grant8(gv, g);
        ld = !m_valid || bus8.out_ready;
        er = '0;
        if (!rst && gv && ld) er[g] = 1'b1;
        chk("in_ready", {24'd0, bus8.in_ready}, {24'd0, er});
        @(posedge clk);
        if (rst) begin
            m_valid = 0;
            m_data  = 0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (gv && ld) begin
            m_valid = 1;
            m_data  = bus8.in_data[g*4 +: 4];
            m_ch    = g;
            if (bus8.mode) m_ptr = (g + 1) % 8;
        end else if (ld) begin
            m_valid = 0;
        end
        #1;
        chk("out_valid", {31'd0, bus8.out_valid}, {31'd0, m_valid});
        chk("out_data", {28'd0, bus8.out_data}, {28'd0, m_data});
        chk("out_ch", {29'd0, bus8.out_ch}, m_ch);
    endtask

    initial begin
        rst            = 1'b1;
        bus8.in_data   = BASE;
        bus8.in_valid  = '0;
        bus8.mode      = 1'b0;
        bus8.sel       = '0;
        bus8.out_ready = 1'b1;
        bus5.in_data   = '0;
        bus5.in_valid  = '0;
        bus5.mode      = 1'b0;
        bus5.sel       = '0;
        bus5.out_ready = 1'b1;
        m_valid = 0;
        m_data  = 0;
        m_ch    = 0;
        m_ptr   = 0;

        // reset state, with valids asserted to show in_ready held low
        bus8.in_valid = 8'hFF;
        step8();
        step8();
        chk("rst_valid5", {31'd0, bus5.out_valid}, 32'd0);
        rst = 1'b0;

        // fixed select sweep
        for (int s = 0; s < 8; s++) begin
            bus8.sel = 3'(s);
            step8();
        end
        chk("sweep_last", {28'd0, bus8.out_data}, 32'hA);

        // round-robin across all channels with wrap
        bus8.mode = 1'b1;
        for (int k = 0; k < 10; k++) step8();
        chk("rr_wrap_ch", {29'd0, bus8.out_ch}, 32'd1);

        // sparse round-robin
        rst = 1'b1;
        step8();
        rst = 1'b0;
        bus8.in_valid = 8'b1010_0100;
        for (int k = 0; k < 4; k++) step8();
        chk("sparse_ch", {29'd0, bus8.out_ch}, 32'd2);

        // backpressure hold while channel data changes
        bus8.mode     = 1'b0;
        bus8.sel      = 3'd3;
        bus8.in_valid = 8'hFF;
        step8();
        bus8.out_ready = 1'b0;
        bus8.in_data[12 +: 4] = 4'h1;
        for (int k = 0; k < 4; k++) step8();
        chk("bp_hold", {28'd0, bus8.out_data}, 32'h7);
        bus8.out_ready = 1'b1;
        step8();
        chk("bp_release", {28'd0, bus8.out_data}, 32'h1);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            rst            = ($urandom_range(0, 49) == 0);
            bus8.in_data   = $urandom;
            bus8.in_valid  = 8'($urandom);
            bus8.mode      = 1'($urandom);
            bus8.sel       = 3'($urandom_range(0, 7));
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            step8();
        end

        // reset while full with ptr at 6
        rst            = 1'b1;
        bus8.in_data   = BASE;
        bus8.in_valid  = '0;
        bus8.out_ready = 1'b1;
        step8();
        rst = 1'b0;
        bus8.mode     = 1'b1;
        bus8.in_valid = 8'b0010_0000;
        step8();
        bus8.out_ready = 1'b0;
        bus8.in_valid  = 8'hFF;
        step8();
        chk("pre_rst_data", {28'd0, bus8.out_data}, 32'hF);
        rst = 1'b1;
        step8();
        chk("rst_full_valid", {31'd0, bus8.out_valid}, 32'd0);
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        step8();
        chk("rst_rr_restart", {29'd0, bus8.out_ch}, 32'd0);

        // N=5: out-of-range sel never grants, then ptr wraps from channel 4
        bus5.in_valid = 5'h1F;
        bus5.in_data  = 20'h9_8763;
        bus5.sel      = 3'd6;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("n5_sel6_ready", {27'd0, bus5.in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("n5_sel6_valid", {31'd0, bus5.out_valid}, 32'd0);
        end
        bus5.mode     = 1'b1;
        bus5.in_valid = 5'b10000;
        #1;
        chk("n5_ready4", {27'd0, bus5.in_ready}, 32'h10);
        @(posedge clk);
        #1;
        chk("n5_ch4", {29'd0, bus5.out_ch}, 32'd4);
        chk("n5_data4", {28'd0, bus5.out_data}, 32'h9);
        bus5.in_valid = 5'h1F;
        #1;
        chk("n5_ready0", {27'd0, bus5.in_ready}, 32'h01);
        @(posedge clk);
        #1;
        chk("n5_wrap_ch", {29'd0, bus5.out_ch}, 32'd0);
        chk("n5_wrap_data", {28'd0, bus5.out_data}, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer; next generation of the 8-to-1 4-bit combinational mux.
- Adds per-channel valid/ready handshakes, a registered output stage with backpressure, and two selection modes: fixed (external sel) and round-robin (internal pointer).
- Sits between several producer lanes and a single consumer in lab datapaths.

Parameters:
- WIDTH, 4, data bits per channel.
- N, 8, number of input channels (2..16; need not be a power of two).
- SELW, $clog2(N), width of sel and out_ch (derived, do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i has data.
- in_ready  output  N  channel i transfers this cycle; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  index of the channel held in out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- On reset: out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0, in_ready=0 in the same cycle rst is high. Reset mid-transfer drops the held word; nothing is replayed.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load_en = !out_valid | out_ready. The output register loads when load_en is high and a grant exists.
- Grant, combinational from current inputs:
  - Fixed mode: grant = sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N never grants.
  - Round-robin mode: grant is the first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1 (wrap modulo N, not 2^SELW).
- in_ready[g] = load_en & grant valid, only for the granted channel g. All other bits of in_ready are 0.
- Transfer occurs when in_valid[g] & in_ready[g]. On the next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- FULL with out_ready=1 and no grant: out_valid <= 0 on the next edge; out_data and out_ch hold their last values.
- FULL with out_ready=0: all outputs hold and in_ready=0 (backpressure).
- Simultaneous drain and load (FULL, out_ready=1, grant present): a new word loads in the same edge. Throughput is one word per cycle, latency is one cycle from the in_valid&in_ready cycle to out_valid.
- Pointer:
  - Round-robin mode: ptr updates only on a transfer, ptr <= (g+1) mod N; g=N-1 wraps ptr to 0.
  - Fixed mode: ptr holds.
- mode and sel are sampled every cycle. Changing them while FULL does not alter the held word.
- in_data and in_valid of unselected channels are ignored. No combinational path from out_ready to out_data.

Test Plan:
- Default parameters; D0..D7 = 6,B,2,7,8,F,C,A; all valid; mode=0; out_ready=1; sel stepped 0..7, one per cycle → out_data sequence 6,B,2,7,8,F,C,A, each one cycle after its sel; out_ch = previous sel; in_ready one-hot at sel.
- Same data, mode=1, all valid, out_ready=1 for 10 cycles → out_ch 0,1,…,7,0,1 and out_data 6,B,2,7,8,F,C,A,6,B (pointer wrap).
- mode=1, in_valid=8'b1010_0100, ptr=0 → grants 2,5,7,2; channels 0,1,3,4,6 never see in_ready.
- mode=0, sel=3, transfer loads 7; hold out_ready=0 for 4 cycles while D3 changes to 1 → out_data stays 7, out_valid=1, in_ready=0; release out_ready → next cycle out_data=1.
- N=5 instance, mode=0, sel=6 → no grant, out_valid stays 0. Then mode=1 with channel 4 granted → ptr wraps to 0.
- Assert rst for one cycle while FULL with out_data=F and ptr=6 → next cycle out_valid=0, out_data=0, out_ch=0; round-robin restarts at channel 0.
